// File: rtl/ram_scan_dp.sv
// Dual-port RAM whose read port scans the address space automatically or by manual step.
// Define RAM_SCAN_BYPASS_EN for write-through on a same-address write/read collision.
module ram_scan_dp #(
  parameter int DATA_W   = 3,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              scan_en,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              step_q, step_d;
  logic              adv_q, adv_d;
  logic              rd_valid_q, rd_valid_d;

  logic tick;
  logic step_pulse;
  logic adv;

  // Storage is intentionally left out of reset.
  always_ff @(posedge clock) begin
    if (wren) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    tick       = scan_en & (div_cnt_q == DIV_MAX);
    step_pulse = step & ~step_q & ~scan_en;
    adv        = tick | step_pulse;

    div_cnt_d = '0;
    if (scan_en && !tick) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    rd_addr_d = rd_addr_q;
    if (adv) begin
      rd_addr_d = rd_addr_q + ADDR_W'(1);
    end

    rd_data_d = mem_q[rd_addr_q];
`ifdef RAM_SCAN_BYPASS_EN
    if (wren && (wr_addr == rd_addr_q)) begin
      rd_data_d = wr_data;
    end
`endif

    step_d     = step;
    adv_d      = adv;
    rd_valid_d = adv_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt_q  <= '0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
      step_q     <= 1'b0;
      adv_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
      step_q     <= step_d;
      adv_q      <= adv_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule
